// File: rtl/abro_pkg.sv
`default_nettype none
// ============================================================================
// Module      : abro_pkg
// Description : Shared types and default constants for the ABRO input
//               conditioner (debounce FSM encoding, default depths).
// Revision    : 1.0 - initial release
// ============================================================================
package abro_pkg;

    typedef enum logic [1:0] {
        STABLE_LO = 2'd0,
        PEND_HI   = 2'd1,
        STABLE_HI = 2'd2,
        PEND_LO   = 2'd3
    } deb_state_t;

    localparam int ABRO_SYNC_STAGES     = 2;
    localparam int ABRO_DEBOUNCE_CYCLES = 16;

endpackage : abro_pkg
`default_nettype wire

// File: rtl/abro_debounce_channel.sv
`default_nettype none
// ============================================================================
// Module      : abro_debounce_channel
// Description : One conditioning channel: flop synchroniser, debounce FSM with
//               persistence counter, registered level and rising-edge pulse.
// Revision    : 1.0 - initial release
// ============================================================================
module abro_debounce_channel
    import abro_pkg::*;
#(
    parameter int SYNC_STAGES     = ABRO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = ABRO_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_in,
    output logic level,
    output logic pulse
);

    localparam int                CNT_W      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CNT_W-1:0]  c_cnt_one  = CNT_W'(1);
    localparam logic [CNT_W-1:0]  c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam bit                c_single   = (DEBOUNCE_CYCLES == 1);

    logic [SYNC_STAGES-1:0] r_sync;
    logic                   w_sync_x;

    deb_state_t             r_state;
    deb_state_t             w_state_nxt;
    logic [CNT_W-1:0]       r_cnt;
    logic [CNT_W-1:0]       w_cnt_nxt;
    logic                   r_level;
    logic                   w_level_nxt;
    logic                   r_pulse;
    logic                   w_pulse_nxt;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync <= '0;
        end else begin
            r_sync <= {r_sync[SYNC_STAGES-2:0], raw_in};
        end
    end

    assign w_sync_x = r_sync[SYNC_STAGES-1];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= STABLE_LO;
            r_cnt   <= '0;
            r_level <= 1'b0;
            r_pulse <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
            r_level <= w_level_nxt;
            r_pulse <= w_pulse_nxt;
        end
    end

    // A single-cycle debounce skips the pending state and commits on the
    // first differing sample.
    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_level_nxt = r_level;
        w_pulse_nxt = 1'b0;
        case (r_state)
            STABLE_LO: begin
                w_cnt_nxt = '0;
                if (w_sync_x) begin
                    if (c_single) begin
                        w_state_nxt = STABLE_HI;
                        w_level_nxt = 1'b1;
                        w_pulse_nxt = 1'b1;
                    end else begin
                        w_state_nxt = PEND_HI;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
            end
            PEND_HI: begin
                if (w_sync_x) begin
                    if (r_cnt == c_cnt_last) begin
                        w_state_nxt = STABLE_HI;
                        w_level_nxt = 1'b1;
                        w_pulse_nxt = 1'b1;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end else begin
                    w_state_nxt = STABLE_LO;
                    w_cnt_nxt   = '0;
                end
            end
            STABLE_HI: begin
                w_cnt_nxt = '0;
                if (!w_sync_x) begin
                    if (c_single) begin
                        w_state_nxt = STABLE_LO;
                        w_level_nxt = 1'b0;
                    end else begin
                        w_state_nxt = PEND_LO;
                        w_cnt_nxt   = c_cnt_one;
                    end
                end
            end
            PEND_LO: begin
                if (!w_sync_x) begin
                    if (r_cnt == c_cnt_last) begin
                        w_state_nxt = STABLE_LO;
                        w_level_nxt = 1'b0;
                        w_cnt_nxt   = '0;
                    end else begin
                        w_cnt_nxt = r_cnt + c_cnt_one;
                    end
                end else begin
                    w_state_nxt = STABLE_HI;
                    w_cnt_nxt   = '0;
                end
            end
            default: begin
                w_state_nxt = STABLE_LO;
                w_cnt_nxt   = '0;
                w_level_nxt = 1'b0;
            end
        endcase
    end

    assign level = r_level;
    assign pulse = r_pulse;

endmodule : abro_debounce_channel
`default_nettype wire

// File: rtl/abro_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : abro_input_conditioner
// Description : Synchronises and debounces the raw A, B and R lines feeding
//               the ABRO machine; three independent identical channels.
// Revision    : 1.0 - initial release
// ============================================================================
module abro_input_conditioner
    import abro_pkg::*;
#(
    parameter int SYNC_STAGES     = ABRO_SYNC_STAGES,
    parameter int DEBOUNCE_CYCLES = ABRO_DEBOUNCE_CYCLES
) (
    input  logic clk,
    input  logic reset,
    input  logic raw_a,
    input  logic raw_b,
    input  logic raw_r,
    output logic a_level,
    output logic b_level,
    output logic r_level,
    output logic a_pulse,
    output logic b_pulse,
    output logic r_pulse
);

    localparam int c_num_ch = 3;

    logic [c_num_ch-1:0] w_raw;
    logic [c_num_ch-1:0] w_level;
    logic [c_num_ch-1:0] w_pulse;

    // Channel index order: 0 = A, 1 = B, 2 = R.
    assign w_raw = {raw_r, raw_b, raw_a};

    for (genvar g = 0; g < c_num_ch; g++) begin : g_ch
        abro_debounce_channel #(
            .SYNC_STAGES     (SYNC_STAGES),
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
        ) u_chan (
            .clk    (clk),
            .reset  (reset),
            .raw_in (w_raw[g]),
            .level  (w_level[g]),
            .pulse  (w_pulse[g])
        );
    end

    assign a_level = w_level[0];
    assign b_level = w_level[1];
    assign r_level = w_level[2];
    assign a_pulse = w_pulse[0];
    assign b_pulse = w_pulse[1];
    assign r_pulse = w_pulse[2];

endmodule : abro_input_conditioner
`default_nettype wire

// File: tb/tb_abro_input_conditioner.sv
`default_nettype none
// ============================================================================
// Module      : tb_abro_input_conditioner
// Description : Self-checking bench; expected pulses are queued when stimulus
//               is driven and matched by a monitor when the DUT pulses.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_abro_input_conditioner;

    localparam int SYNC_STAGES     = 2;
    localparam int DEBOUNCE_CYCLES = 4;
    localparam int LAT             = SYNC_STAGES + DEBOUNCE_CYCLES;

    typedef struct {
        int ch;
        int cyc;
    } exp_t;

    logic clk;
    logic rst_n;
    logic raw_a, raw_b, raw_r;
    logic a_level, b_level, r_level;
    logic a_pulse, b_pulse, r_pulse;

    int   cyc;
    int   n_checks;
    int   n_errors;
    exp_t sb[$];
    exp_t mon_e;

    logic [2:0] levels;
    logic [2:0] pulses;
    assign levels = {r_level, b_level, a_level};
    assign pulses = {r_pulse, b_pulse, a_pulse};

    abro_input_conditioner #(
        .SYNC_STAGES     (SYNC_STAGES),
        .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) dut (
        .clk     (clk),
        .reset   (rst_n),
        .raw_a   (raw_a),
        .raw_b   (raw_b),
        .raw_r   (raw_r),
        .a_level (a_level),
        .b_level (b_level),
        .r_level (r_level),
        .a_pulse (a_pulse),
        .b_pulse (b_pulse),
        .r_pulse (r_pulse)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc = cyc + 1;

    // Scoreboard monitor: every pulse must match the head of the queue, and
    // an entry whose cycle has passed without a pulse is a missed pulse.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].cyc < cyc) begin
            mon_e = sb.pop_front();
            n_checks++;
            n_errors++;
            $display("FAIL pulse_missing ch=%0d got no pulse, required pulse at cycle %0d", mon_e.ch, mon_e.cyc);
        end
        for (int ch = 0; ch < 3; ch++) begin
            if (pulses[ch]) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_errors++;
                    $display("FAIL pulse_unexpected ch=%0d got pulse at cycle %0d, required none", ch, cyc);
                end else begin
                    mon_e = sb.pop_front();
                    if (mon_e.ch !== ch || mon_e.cyc !== cyc) begin
                        n_errors++;
                        $display("FAIL pulse_match got ch=%0d cycle=%0d, required ch=%0d cycle=%0d", ch, cyc, mon_e.ch, mon_e.cyc);
                    end
                end
            end
        end
    end

    task automatic step(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic push_exp(input int ch, input int at);
        exp_t e;
        e.ch  = ch;
        e.cyc = at;
        sb.push_back(e);
    endtask

    task automatic test_reset;
        int c;
        rst_n = 1'b0;
        raw_a = 1'b1; raw_b = 1'b1; raw_r = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            n_checks++;
            if ({levels, pulses} !== 6'b0) begin
                n_errors++;
                $display("FAIL reset_hold got levels/pulses=%b, required 000000", {levels, pulses});
            end
        end
        rst_n = 1'b1;
        c = cyc;
        push_exp(0, c + LAT); push_exp(1, c + LAT); push_exp(2, c + LAT);
        step(LAT - 1);
        n_checks++;
        if (levels !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_release_early got levels=%b, required 000", levels);
        end
        step(1);
        n_checks++;
        if (levels !== 3'b111 || pulses !== 3'b111) begin
            n_errors++;
            $display("FAIL reset_release_rise got levels=%b pulses=%b, required 111/111", levels, pulses);
        end
        step(2);
        raw_a = 1'b0; raw_b = 1'b0; raw_r = 1'b0;
        step(LAT + 2);
        n_checks++;
        if (levels !== 3'b000) begin
            n_errors++;
            $display("FAIL reset_drop got levels=%b, required 000", levels);
        end
    endtask

    task automatic test_clean_press;
        int c;
        raw_a = 1'b1;
        c = cyc;
        push_exp(0, c + LAT);
        step(LAT - 1);
        n_checks++;
        if (a_level !== 1'b0) begin
            n_errors++;
            $display("FAIL press_early got a_level=%b, required 0", a_level);
        end
        step(1);
        n_checks++;
        if (a_level !== 1'b1 || a_pulse !== 1'b1 || b_level !== 1'b0 || r_level !== 1'b0) begin
            n_errors++;
            $display("FAIL press_rise got a_level=%b a_pulse=%b b=%b r=%b, required 1 1 0 0", a_level, a_pulse, b_level, r_level);
        end
        step(1);
        n_checks++;
        if (a_pulse !== 1'b0 || a_level !== 1'b1) begin
            n_errors++;
            $display("FAIL press_pulse_width got a_pulse=%b a_level=%b, required 0 1", a_pulse, a_level);
        end
        raw_a = 1'b0;
        step(LAT + 2);
    endtask

    task automatic test_bounce;
        int c;
        int seg_len[4];
        seg_len = '{3, 1, 3, 1};
        for (int s = 0; s < 4; s++) begin
            raw_a = (s % 2 == 0) ? 1'b1 : 1'b0;
            for (int i = 0; i < seg_len[s]; i++) begin
                @(negedge clk);
                n_checks++;
                if (a_level !== 1'b0) begin
                    n_errors++;
                    $display("FAIL bounce_level got a_level=%b, required 0", a_level);
                end
            end
        end
        step(LAT);
        n_checks++;
        if (a_level !== 1'b0) begin
            n_errors++;
            $display("FAIL bounce_settle got a_level=%b, required 0", a_level);
        end
        raw_a = 1'b1;
        c = cyc;
        push_exp(0, c + LAT);
        step(LAT);
        n_checks++;
        if (a_level !== 1'b1) begin
            n_errors++;
            $display("FAIL bounce_final got a_level=%b, required 1", a_level);
        end
        step(2);
    endtask

    task automatic test_release;
        int c;
        raw_a = 1'b0;
        c = cyc;
        step(LAT - 1);
        n_checks++;
        if (a_level !== 1'b1) begin
            n_errors++;
            $display("FAIL release_early got a_level=%b, required 1", a_level);
        end
        step(1);
        n_checks++;
        if (a_level !== 1'b0) begin
            n_errors++;
            $display("FAIL release_fall got a_level=%b, required 0", a_level);
        end
        raw_a = 1'b1;
        c = cyc;
        push_exp(0, c + LAT);
        step(LAT + 2);
        raw_a = 1'b0;
        step(2);
        raw_a = 1'b1;
        for (int i = 0; i < LAT + 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (a_level !== 1'b1) begin
                n_errors++;
                $display("FAIL release_glitch got a_level=%b, required 1", a_level);
            end
        end
        raw_a = 1'b0;
        step(LAT + 2);
    endtask

    task automatic test_simultaneous;
        int c;
        raw_a = 1'b1; raw_b = 1'b1; raw_r = 1'b1;
        c = cyc;
        push_exp(0, c + LAT); push_exp(1, c + LAT);
        step(1);
        raw_r = 1'b0;
        step(LAT - 1);
        n_checks++;
        if (pulses !== 3'b011 || levels !== 3'b011) begin
            n_errors++;
            $display("FAIL simul_rise got pulses=%b levels=%b, required 011/011", pulses, levels);
        end
        step(1);
        n_checks++;
        if (pulses !== 3'b000) begin
            n_errors++;
            $display("FAIL simul_width got pulses=%b, required 000", pulses);
        end
        raw_a = 1'b0; raw_b = 1'b0;
        step(LAT + 2);
    endtask

    task automatic test_reset_mid;
        int c;
        raw_r = 1'b1;
        step(4);
        rst_n = 1'b0;
        #1;
        n_checks++;
        if (r_level !== 1'b0 || r_pulse !== 1'b0) begin
            n_errors++;
            $display("FAIL midreset_assert got r_level=%b r_pulse=%b, required 0 0", r_level, r_pulse);
        end
        step(3);
        n_checks++;
        if (levels !== 3'b000) begin
            n_errors++;
            $display("FAIL midreset_hold got levels=%b, required 000", levels);
        end
        rst_n = 1'b1;
        c = cyc;
        push_exp(2, c + LAT);
        step(LAT);
        n_checks++;
        if (r_level !== 1'b1) begin
            n_errors++;
            $display("FAIL midreset_rise got r_level=%b, required 1", r_level);
        end
        step(LAT);
        raw_r = 1'b0;
        step(LAT + 2);
    endtask

    initial begin
        n_checks = 0;
        n_errors = 0;
        rst_n = 1'b0;
        raw_a = 1'b0; raw_b = 1'b0; raw_r = 1'b0;
        test_reset();
        test_clean_press();
        test_bounce();
        test_release();
        test_simultaneous();
        test_reset_mid();
        step(2);
        n_checks++;
        if (sb.size() != 0) begin
            n_errors++;
            $display("FAIL scoreboard_drain got %0d pending pulses, required 0", sb.size());
        end
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got timeout, required completion");
        $fatal(1, "timeout");
    end

endmodule : tb_abro_input_conditioner
`default_nettype wire
